// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: SPI scan sequencer for the 8-channel soil-sensor ADC (cs_n/sclk/din, dout capture).
// Rev 1.0 - initial release
`default_nettype none

module adc_scan_ctrl #(
  parameter int CLK_DIV = 12,
  parameter int NUM_CH  = 8,
  parameter int CS_GAP  = 50
) (
  input  logic        clk_25M,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic        dout,
  output logic        cs_n,
  output logic        sclk,
  output logic        din,
  output logic [11:0] data,
  output logic [2:0]  data_ch,
  output logic        data_valid,
  output logic        busy
);

  localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] c_GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [3:0] c_NUM_CH   = 4'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [4:0]  r_half, w_half_nxt;
  logic [3:0]  r_f, w_f_nxt;
  logic [11:0] r_sh, w_sh_nxt;
  logic [1:0]  r_sync;
  logic        r_cs_n, w_cs_nxt;
  logic        r_sclk, w_sclk_nxt;
  logic        r_din, w_din_nxt;
  logic [11:0] r_data, w_data_nxt;
  logic [2:0]  r_ch, w_ch_nxt;
  logic        r_dv, w_dv_nxt;
  logic        r_busy, w_busy_nxt;

  logic [2:0]  w_addr;
  logic [3:0]  w_k_next;
  logic        w_last_div;
  logic        w_last_gap;

  // The extra frame at f == NUM_CH only flushes out the final pipelined result.
  assign w_addr     = (r_f < c_NUM_CH) ? r_f[2:0] : 3'd0;
  assign w_k_next   = r_half[4:1] + 4'd1;
  assign w_last_div = (r_cnt == c_DIV_LAST);
  assign w_last_gap = (r_cnt == c_GAP_LAST);

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], dout};
    end
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_half  <= 5'd0;
      r_f     <= 4'd0;
      r_sh    <= 12'd0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
      r_din   <= 1'b0;
      r_data  <= 12'd0;
      r_ch    <= 3'd0;
      r_dv    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_f     <= w_f_nxt;
      r_sh    <= w_sh_nxt;
      r_cs_n  <= w_cs_nxt;
      r_sclk  <= w_sclk_nxt;
      r_din   <= w_din_nxt;
      r_data  <= w_data_nxt;
      r_ch    <= w_ch_nxt;
      r_dv    <= w_dv_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 8'd1;
    w_half_nxt  = r_half;
    w_f_nxt     = r_f;
    w_sh_nxt    = r_sh;
    w_cs_nxt    = r_cs_n;
    w_sclk_nxt  = r_sclk;
    w_din_nxt   = r_din;
    w_data_nxt  = r_data;
    w_ch_nxt    = r_ch;
    w_dv_nxt    = 1'b0;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 8'd0;
        if (start || cont) begin
          w_state_nxt = S_SETUP;
          w_busy_nxt  = 1'b1;
          w_f_nxt     = 4'd0;
          w_cs_nxt    = 1'b0;
          w_sclk_nxt  = 1'b1;
          w_din_nxt   = 1'b0;
        end
      end
      S_SETUP: begin
        if (w_last_div) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = 8'd0;
          w_half_nxt  = 5'd0;
          w_sclk_nxt  = 1'b0;
          w_din_nxt   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (w_last_div) begin
          w_cnt_nxt = 8'd0;
          if (r_half == 5'd31) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_half_nxt = r_half + 5'd1;
            w_sclk_nxt = ~r_sclk;
            if (r_half[0]) begin
              // Falling edge: present the address bit for the next period.
              case (w_k_next)
                4'd2:    w_din_nxt = w_addr[2];
                4'd3:    w_din_nxt = w_addr[1];
                4'd4:    w_din_nxt = w_addr[0];
                default: w_din_nxt = 1'b0;
              endcase
            end else if (r_half[4:1] >= 4'd4) begin
              w_sh_nxt = {r_sh[10:0], r_sync[1]};
            end
          end
        end
      end
      S_HOLD: begin
        if (w_last_div) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = 8'd0;
          w_cs_nxt    = 1'b1;
          if (r_f != 4'd0) begin
            w_dv_nxt   = 1'b1;
            w_data_nxt = r_sh;
            w_ch_nxt   = r_f[2:0] - 3'd1;
          end
        end
      end
      S_GAP: begin
        if (w_last_gap) begin
          w_cnt_nxt = 8'd0;
          if (r_f < c_NUM_CH) begin
            w_f_nxt     = r_f + 4'd1;
            w_state_nxt = S_SETUP;
            w_cs_nxt    = 1'b0;
          end else if (cont) begin
            w_f_nxt     = 4'd0;
            w_state_nxt = S_SETUP;
            w_cs_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cs_n       = r_cs_n;
  assign sclk       = r_sclk;
  assign din        = r_din;
  assign data       = r_data;
  assign data_ch    = r_ch;
  assign data_valid = r_dv;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: randomized bench with an ADC model and a frame-timing reference model.
// Rev 1.0 - initial release
`default_nettype none

module tb_adc_scan_ctrl;

  localparam int c_CD0 = 12;
  localparam int c_L0  = 458;
  localparam int c_S0  = 4122;

  logic        clk;
  logic        rst_n;
  logic [1:0]  st, ct;
  logic [1:0]  cs_a, sc_a, di_a, dv_a, busy_a;
  logic [11:0] data_a [2];
  logic [2:0]  ch_a [2];

  int          n_pass;
  int          n_total;
  int          dv_cnt [2];
  logic [11:0] last_data [2];
  logic [2:0]  last_ch [2];
  int          win_log [2];
  logic [2:0]  addr_log [2][16];
  bit          mon_en [2];

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, a, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  for (genvar i = 0; i < 2; i++) begin : g_inst
    localparam int CD   = (i == 0) ? 12 : 4;
    localparam int NC   = (i == 0) ? 8 : 1;
    localparam int GP   = (i == 0) ? 50 : 1;
    localparam int EXPF = (i == 0) ? 458 : 137;
    localparam int L    = 34 * CD + GP;
    localparam int S    = (NC + 1) * L;

    logic dout_l;

    adc_scan_ctrl #(.CLK_DIV(CD), .NUM_CH(NC), .CS_GAP(GP)) u_dut (
      .clk_25M    (clk),
      .rst_n      (rst_n),
      .start      (st[i]),
      .cont       (ct[i]),
      .dout       (dout_l),
      .cs_n       (cs_a[i]),
      .sclk       (sc_a[i]),
      .din        (di_a[i]),
      .data       (data_a[i]),
      .data_ch    (ch_a[i]),
      .data_valid (dv_a[i]),
      .busy       (busy_a[i])
    );

    // ADC: shifts out the conversion of the previous frame's address after each sclk fall.
    initial begin : p_adc
      logic [2:0]  a;
      logic [11:0] word;
      logic        pc, ps, pm;
      int          k, mw;
      bit          havef;
      time         te, tcs;
      a = 3'd0; word = 12'd0; k = 0; mw = 0; havef = 0; pm = 0;
      te = 0; tcs = 0; pc = 1'b1; ps = 1'b1; dout_l = 1'b0; win_log[i] = 0;
      forever begin
        @(sc_a[i] or cs_a[i]);
        if (cs_a[i] && !pc) begin
          if (mon_en[i] && pm) begin
            chk($sformatf("falls_per_window_inst%0d", i), 32'(k), 32'd16);
            addr_log[i][mw] = a;
            mw++;
            win_log[i] = mw;
          end
          word   = 12'hA00 + {9'd0, a};
          k      = 0;
          dout_l = 1'b0;
        end else if (!cs_a[i] && pc) begin
          a = 3'd0;
          k = 0;
          if (mon_en[i]) begin
            if (!pm) begin
              mw = 0; havef = 0; win_log[i] = 0;
            end
            if (havef)
              chk($sformatf("frame_spacing_inst%0d", i), 32'(($time - tcs) / 40), 32'(EXPF));
            havef = 1;
            tcs   = $time;
          end
          pm = mon_en[i];
        end else if (!cs_a[i] && ps && !sc_a[i]) begin
          dout_l = (k >= 4) ? word[15-k] : 1'b0;
          if (mon_en[i] && k > 0)
            chk($sformatf("sclk_high_inst%0d", i), 32'(($time - te) / 40), 32'(CD));
          te = $time;
          k++;
        end else if (!cs_a[i] && !ps && sc_a[i]) begin
          if (mon_en[i])
            chk($sformatf("sclk_low_inst%0d", i), 32'(($time - te) / 40), 32'(CD));
          te = $time;
          if (k - 1 >= 2 && k - 1 <= 4) a[5-k] = di_a[i];
        end
        pc = cs_a[i];
        ps = sc_a[i];
      end
    end

    // Reference: position within the scan as a plain cycle offset, outputs derived arithmetically.
    initial begin : p_model
      int          off, f, o, h, kk;
      bit          act;
      logic [11:0] md;
      logic [2:0]  mc, ea;
      logic        ecs, esc, edi, edv;
      logic [19:0] e, got;
      off = 0; act = 0; md = 12'd0; mc = 3'd0; dv_cnt[i] = 0;
      last_data[i] = 12'd0; last_ch[i] = 3'd0;
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          act = 0; md = 12'd0; mc = 3'd0;
        end else if (!act) begin
          if (st[i] || ct[i]) begin act = 1; off = 0; end
        end else begin
          off++;
          if (off == S) begin
            if (ct[i]) off = 0;
            else act = 0;
          end
        end
        if (rst_n && act && (off % L == 34 * CD) && (off / L >= 1)) begin
          md = 12'hA00 + 12'(off / L - 1);
          mc = 3'(off / L - 1);
        end
        @(negedge clk);
        if (!rst_n) begin
          e = {3'b110, 2'b00, 12'h000, 3'h0};
        end else if (!act) begin
          e = {3'b110, 2'b00, md, mc};
        end else begin
          f = off / L; o = off % L;
          ea = (f < NC) ? 3'(f) : 3'd0;
          ecs = 1'b0; esc = 1'b1; edi = 1'b0; edv = 1'b0;
          if (o >= CD && o < 33 * CD) begin
            h = (o - CD) / CD; kk = h / 2;
            esc = (h % 2 == 1);
            if (kk >= 2 && kk <= 4) edi = ea[4-kk];
          end else if (o >= 34 * CD) begin
            ecs = 1'b1;
            edv = (o == 34 * CD) && (f >= 1);
          end
          e = {ecs, esc, edi, 1'b1, edv, md, mc};
        end
        got = {cs_a[i], sc_a[i], di_a[i], busy_a[i], dv_a[i], data_a[i], ch_a[i]};
        chk($sformatf("cycle_inst%0d", i), {12'd0, got}, {12'd0, e});
        if (dv_a[i]) begin
          dv_cnt[i]++;
          last_data[i] = data_a[i];
          last_ch[i]   = ch_a[i];
        end
      end
    end
  end

  task automatic pulse(input int inst, input bit with_cont);
    st[inst] = 1'b1;
    if (with_cont) ct[inst] = 1'b1;
    tick(1);
    st[inst] = 1'b0;
    if (with_cont) ct[inst] = 1'b0;
  endtask

  task automatic run(input int inst, input int n, input bit noise);
    for (int j = 0; j < n; j++) begin
      if (noise && busy_a[inst] && $urandom_range(0, 399) == 0) pulse(inst, 1'b0);
      else tick(1);
    end
  endtask

  task automatic wait_idle(input int inst, input int budget, input bit noise, input string nm);
    int n;
    n = 0;
    while (busy_a[inst] && n < budget) begin
      if (noise && $urandom_range(0, 399) == 0) pulse(inst, 1'b0);
      else tick(1);
      n++;
    end
    chk(nm, {31'd0, busy_a[inst]}, 32'd0);
  endtask

  initial begin
    int b;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; st = 2'b00; ct = 2'b00;
    mon_en[0] = 0; mon_en[1] = 0;

    for (int j = 0; j < 10; j++) begin
      tick(1);
      st = 2'($urandom); ct = 2'($urandom);
    end
    st = 2'b00; ct = 2'b00;
    tick(1);
    rst_n = 1'b1;
    tick(8);
    chk("busy_after_release", {30'd0, busy_a}, 32'd0);
    chk("cs_after_release", {30'd0, cs_a}, 32'd3);

    b = dv_cnt[1];
    pulse(1, 1'b1);
    wait_idle(1, 1000, 1'b0, "nc1_idle");
    tick(300);
    chk("nc1_valid_count", 32'(dv_cnt[1] - b), 32'd1);
    chk("nc1_last_ch", {29'd0, last_ch[1]}, 32'd0);
    chk("nc1_last_data", {20'd0, last_data[1]}, 32'h0A00);
    chk("nc1_stays_idle", {31'd0, busy_a[1]}, 32'd0);

    mon_en[0] = 1;
    b = dv_cnt[0];
    tick($urandom_range(1, 20));
    pulse(0, 1'b0);
    wait_idle(0, c_S0 + 100, 1'b1, "single_idle");
    tick(2);
    mon_en[0] = 0;
    chk("single_valid_count", 32'(dv_cnt[0] - b), 32'd8);
    chk("single_last_data", {20'd0, last_data[0]}, 32'h0A07);
    chk("single_last_ch", {29'd0, last_ch[0]}, 32'd7);
    chk("single_windows", 32'(win_log[0]), 32'd9);
    chk("din_frame1", {29'd0, addr_log[0][1]}, 32'd1);
    chk("din_frame5", {29'd0, addr_log[0][5]}, 32'd5);
    chk("din_frame8", {29'd0, addr_log[0][8]}, 32'd0);

    b = dv_cnt[0];
    ct[0] = 1'b1;
    run(0, 2 * c_S0 + c_S0 / 2 + int'($urandom_range(0, c_S0 / 4)), 1'b1);
    ct[0] = 1'b0;
    wait_idle(0, c_S0 + 100, 1'b1, "cont_idle");
    chk("cont_valid_count", 32'(dv_cnt[0] - b), 32'd24);
    chk("cont_last_ch", {29'd0, last_ch[0]}, 32'd7);

    pulse(0, 1'b0);
    tick(3 * c_L0 + 15 * c_CD0 + 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_cs_n", {31'd0, cs_a[0]}, 32'd1);
    chk("async_sclk", {31'd0, sc_a[0]}, 32'd1);
    chk("async_busy", {31'd0, busy_a[0]}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    b = dv_cnt[0];
    pulse(0, 1'b0);
    wait_idle(0, c_S0 + 100, 1'b0, "post_reset_idle");
    chk("post_reset_valid_count", 32'(dv_cnt[0] - b), 32'd8);
    chk("post_reset_last_data", {20'd0, last_data[0]}, 32'h0A07);

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Sequences the soil-sensor SPI ADC (8-channel, 16-clock frame, 3-bit address on DIN, 12-bit result on DOUT, result pipelined one frame late).
- Generates cs_n, sclk and din from clk_25M, captures dout, and scans channels 0..NUM_CH-1.
- Delivers one tagged 12-bit sample per channel to the moisture/telemetry logic.

Parameters:
- CLK_DIV, 12: clk_25M cycles per sclk half-period (sclk = 25 MHz / (2*CLK_DIV)); legal range 4..255.
- NUM_CH, 8: channels per scan (1..8); addresses 0..NUM_CH-1.
- CS_GAP, 50: clk_25M cycles cs_n is held high between frames (1..255).

Ports:
- clk_25M  in  1  system clock, 25 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request for a single scan; sampled in IDLE only
- cont  in  1  continuous mode; while high, a new scan starts automatically after each scan
- dout  in  1  ADC serial data out (asynchronous to clk_25M)
- cs_n  out  1  ADC chip select, active low
- sclk  out  1  ADC serial clock; idles high
- din  out  1  ADC serial data in
- data  out  12  last captured sample
- data_ch  out  3  channel the sample belongs to
- data_valid  out  1  one-cycle strobe; data/data_ch are valid on this cycle and held afterwards
- busy  out  1  high from scan acceptance until return to IDLE

Behaviour:
- Reset (async assert, sync release): cs_n=1, sclk=1, din=0, data=0, data_ch=0, data_valid=0, busy=0, FSM=IDLE. All counters clear. The dout synchronizer clears to 0.
- dout passes through a 2-flop synchronizer before use. CLK_DIV>=4 guarantees settling before the sample point.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if start or cont, go to SETUP next cycle, set busy=1, frame index f=0. If both are high, a single scan is started, with the same behaviour.
- SETUP: cs_n=0, sclk=1 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 16 sclk periods, k=0..15. Each period is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
  - din updates on the cycle sclk falls.
  - din = addr[2] at k=2, addr[1] at k=3, addr[0] at k=4; 0 for all other k.
  - addr = f for f<NUM_CH, and 0 for f=NUM_CH.
  - Synchronized dout is sampled on the cycle sclk rises. Bits k=4..15 shift into a 12-bit register MSB-first (k=4 is D11). Bits k=0..3 are ignored.
  - After the high phase of k=15, go to HOLD.
- HOLD: sclk=1, cs_n=0 for CLK_DIV cycles, then cs_n=1 and go to GAP.
- GAP: cs_n=1 for CS_GAP cycles.
  - On the first GAP cycle, for f>=1 only: data_valid=1, data=shift register, data_ch=f-1. Frame 0 data is discarded because it is the stale conversion.
  - At GAP end: if f<NUM_CH, increment f and go to SETUP. Otherwise the scan is done: go to SETUP with f=0 if cont=1; else go to IDLE with busy=0.
- A scan is NUM_CH+1 frames and yields exactly NUM_CH data_valid pulses, channels 0..NUM_CH-1 in order.
- Frame length = CLK_DIV*34 + CS_GAP cycles (SETUP + 32 half-periods + HOLD + GAP).
- start while busy is ignored and not queued.
- cont deasserted mid-scan: the current scan completes fully, then the FSM goes to IDLE.
- Reset mid-frame: outputs return to reset values immediately. A partial frame produces no data_valid.
- sclk, cs_n and din are driven directly from registers, with no combinational paths from inputs.

Test Plan:
- Reset: hold rst_n=0, toggle start and cont -> cs_n=1, sclk=1, din=0, busy=0, data_valid=0 throughout. Release -> state unchanged until start.
- Single scan, defaults: ADC model returns 0xA00+prev_addr, one frame late -> 8 data_valid pulses with data_ch=0..7 and data=0xA00..0xA07. Also check:
  - 9 cs_n low windows per scan.
  - 16 sclk falls per window.
  - sclk half-period = 12 cycles.
  - Spacing between frames = 458 cycles.
  - busy drops after the 9th GAP.
- DIN encoding: in frame f=5, din at k=2,3,4 = 1,0,1; all other bits 0. In frame 8, address = 0.
- Continuous: cont=1 for 2.5 scans, then 0 -> 24 data_valid pulses, channel order 0..7 repeating, then IDLE. start pulses while busy produce no extra frames.
- Reset mid-frame: assert rst_n at frame 3, k=7 -> cs_n rises asynchronously, no data_valid. After release and start, a full scan from ch0 runs correctly.
- Boundaries: NUM_CH=1, CLK_DIV=4, CS_GAP=1 -> 2 frames per scan, one data_valid with data_ch=0 and the correct data. start and cont asserted together in IDLE produce a single scan.
